output_drain: RTL and testbench
===============================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 30: number of filter outputs selectable.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: width of signed filter result (F_WIDTH+I_WIDTH).
REQ-003 SHALL have parameter OUT_WIDTH, default 8: width of signed quantized output.
REQ-004 SHALL have parameter SEL_WIDTH, default $clog2(NUM_FILTERS)=5: filter index width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries (power of two).
REQ-006 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port general_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port start_i  in  1  single-cycle request to begin a drain pass.
REQ-009 SHALL have port num_filters_i  in  SEL_WIDTH+1  filters to drain; sampled on accepted start.
REQ-010 SHALL have port shift_i  in  4  right-shift amount; sampled on accepted start.
REQ-011 SHALL have port relu_en_i  in  1  clamp negatives to 0; sampled on accepted start.
REQ-012 SHALL have port sel_mux_final_o  out  SEL_WIDTH  index driven to upstream result selector.
REQ-013 SHALL have port final_output_i  in  ACC_WIDTH  signed result for index on sel_mux_final_o, same cycle (combinational upstream).
REQ-014 SHALL have ports out_valid_o out 1, out_ready_i in 1, out_data_o out OUT_WIDTH, out_idx_o out SEL_WIDTH, out_last_o out 1: downstream stream.
REQ-015 SHALL have ports busy_o out 1 (pass in progress) and done_o out 1 (one-cycle pass-complete pulse).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, FLUSH, DONE.
REQ-017 IDLE: start_i=1 SHALL latch num_filters_i, shift_i, relu_en_i, clear index counter, go ISSUE; start_i in any other state SHALL be ignored.
REQ-018 num_filters_i greater than NUM_FILTERS SHALL be clamped to NUM_FILTERS; num_filters_i=0 SHALL go IDLE->DONE directly with no stream output.
REQ-019 ISSUE: sel_mux_final_o SHALL equal index counter; issue occurs in a cycle when fifo_count + s1_valid < FIFO_DEPTH; on issue final_output_i and index SHALL be registered into stage S1 and index incremented.
REQ-020 After issuing index num_filters-1, FSM SHALL go FLUSH; FLUSH SHALL go DONE when S1 empty, FIFO empty, and no transfer pending.
REQ-021 DONE SHALL last one cycle, assert done_o, and return to IDLE; busy_o SHALL be 1 in ISSUE and FLUSH only.
REQ-022 S1->FIFO quantization: if shift>0 add 2^(shift-1), then arithmetic right shift by shift, in ACC_WIDTH+1 bits without overflow; if relu_en and result<0 then 0; saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-023 S1 valid SHALL always write FIFO next edge (space guaranteed by REQ-019); FIFO entry SHALL carry data, idx, last (idx==num_filters-1).
REQ-024 Latency: start accepted edge N, issue in cycle N+1, out_valid_o high in cycle N+3 with FIFO non-full.
REQ-025 out_valid_o SHALL equal FIFO non-empty; pop on out_valid_o & out_ready_i; out_data_o/out_idx_o/out_last_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-026 Simultaneous FIFO push and pop SHALL keep count unchanged, including when full (issue blocked that cycle by REQ-019 regardless of pop).
REQ-027 Outputs SHALL emerge in strictly ascending idx order 0..num_filters-1, no loss, no duplication.
REQ-028 sel_mux_final_o SHALL hold last value outside ISSUE.

Reset
REQ-029 While general_rst_ni=0, SHALL force IDLE, index 0, S1 empty, FIFO empty, latched config 0; outputs sel_mux_final_o=0, out_valid_o=0, out_data_o=0, out_idx_o=0, out_last_o=0, busy_o=0, done_o=0.
REQ-030 Reset asserted mid-pass SHALL discard all in-flight data; after deassertion no output until new start_i.

Verification
REQ-031 num=3, shift=0, relu=0, results {100,-5,300}, ready=1 -> outputs 100 idx0, -5 idx1, 127 idx2 last=1; first valid 3 cycles after start; done_o one pulse.
REQ-032 num=2, shift=4, relu=1, results {-40, 24} -> 0 idx0, 2 idx1 (24+8=32>>4) last=1.
REQ-033 num=30, out_ready_i=0 for 20 cycles then 1 -> FIFO holds 4, issue stalls with sel_mux_final_o=4, then all 30 in order, done_o after idx29 popped.
REQ-034 num_filters_i=0 -> done_o pulse cycle after start, out_valid_o never asserted; num_filters_i=31 -> exactly 30 outputs.
REQ-035 Reset low during pass at idx 10 with FIFO full -> out_valid_o=0, busy_o=0 immediately; re-start num=1 -> single output idx0 last=1.
REQ-036 start_i pulsed while busy_o=1 -> ignored, output count and config unchanged.

Source files
------------

// File: rtl/output_drain.sv
// output_drain: walks filter results 0..num_filters-1 through an upstream
// result selector, quantizes each one (round, shift, optional ReLU, saturate)
// and streams them out through a small ready/valid FIFO. Issue stalls when the
// FIFO plus the in-flight S1 stage would overflow, so S1 can always write.
module output_drain #(
    parameter int NUM_FILTERS = 30,
    parameter int ACC_WIDTH   = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SEL_WIDTH   = $clog2(NUM_FILTERS),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        general_rst_ni,
    input  logic                        start_i,
    input  logic [SEL_WIDTH:0]          num_filters_i,
    input  logic [3:0]                  shift_i,
    input  logic                        relu_en_i,
    output logic [SEL_WIDTH-1:0]        sel_mux_final_o,
    input  logic signed [ACC_WIDTH-1:0] final_output_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [OUT_WIDTH-1:0] out_data_o,
    output logic [SEL_WIDTH-1:0]        out_idx_o,
    output logic                        out_last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [SEL_WIDTH:0] NUM_MAX = (SEL_WIDTH+1)'(NUM_FILTERS);
    localparam logic [CW:0]        DEPTH_C = (CW+1)'(FIFO_DEPTH);

    // Saturation bounds expressed in the widened quantizer width.
    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((2**(OUT_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(-(2**(OUT_WIDTH-1)));
    localparam logic [OUT_WIDTH-1:0]      OUT_HI = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]      OUT_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched pass configuration and the issue index.
    logic [SEL_WIDTH:0]   num_q;
    logic [3:0]           shift_q;
    logic                 relu_q;
    logic [SEL_WIDTH:0]   idx_q;
    logic [SEL_WIDTH-1:0] sel_q;

    // S1: registered upstream result waiting to be quantized into the FIFO.
    logic                        s1_valid_q;
    logic signed [ACC_WIDTH-1:0] s1_data_q;
    logic [SEL_WIDTH-1:0]        s1_idx_q;

    // Output FIFO.
    logic [OUT_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [SEL_WIDTH-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic                 fifo_last_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;

    logic [SEL_WIDTH:0]   num_clamped;
    logic [CW:0]          occupancy;
    logic                 issue, last_issue, push, pop, start_acc;

    logic signed [ACC_WIDTH:0] q_ext, q_round, q_shift;
    logic [ACC_WIDTH:0]        q_rnd;
    logic [OUT_WIDTH-1:0]      q_out;
    logic                      s1_last;

    assign num_clamped = (num_filters_i > NUM_MAX) ? NUM_MAX : num_filters_i;
    assign start_acc   = (state_q == IDLE) && start_i;

    // An issue is only allowed when the entry it creates is guaranteed a FIFO slot,
    // counting the one possibly still sitting in S1; a same-cycle pop does not help.
    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
    assign issue      = (state_q == ISSUE) && (occupancy < DEPTH_C);
    assign last_issue = issue && (idx_q == (num_q - (SEL_WIDTH+1)'(1)));

    assign push = s1_valid_q;
    assign pop  = out_valid_o && out_ready_i;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!s1_valid_q && (count_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pass configuration capture and issue index counter.
    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            num_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            idx_q   <= '0;
        end else if (start_acc) begin
            num_q   <= num_clamped;
            shift_q <= shift_i;
            relu_q  <= relu_en_i;
            idx_q   <= '0;
        end else if (issue) begin
            idx_q   <= idx_q + (SEL_WIDTH+1)'(1);
        end
    end

    // Remember the selector value seen during ISSUE so it holds afterwards
    // even though the index has already moved past the last filter.
    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            sel_q <= '0;
        end else if (state_q == ISSUE) begin
            sel_q <= idx_q[SEL_WIDTH-1:0];
        end
    end

    assign sel_mux_final_o = (state_q == ISSUE) ? idx_q[SEL_WIDTH-1:0] : sel_q;

    // S1 capture of the combinational upstream result.
    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= issue;
            if (issue) begin
                s1_data_q <= final_output_i;
                s1_idx_q  <= idx_q[SEL_WIDTH-1:0];
            end
        end
    end

    // Quantizer: round-half-up, arithmetic shift in one extra bit, ReLU, saturate.
    always_comb begin
        q_ext   = {s1_data_q[ACC_WIDTH-1], s1_data_q};
        q_rnd   = '0;
        if (shift_q != 4'd0) begin
            q_rnd = (ACC_WIDTH+1)'(1) << (shift_q - 4'd1);
        end
        q_round = q_ext + $signed(q_rnd);
        q_shift = q_round >>> shift_q;
        q_out   = q_shift[OUT_WIDTH-1:0];
        if (relu_q && (q_shift < 0)) begin
            q_out = '0;
        end else if (q_shift > SAT_HI) begin
            q_out = OUT_HI;
        end else if (q_shift < SAT_LO) begin
            q_out = OUT_LO;
        end
    end

    assign s1_last = ({1'b0, s1_idx_q} == (num_q - (SEL_WIDTH+1)'(1)));

    // FIFO storage; contents need no reset because the outputs are gated by valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= q_out;
            fifo_idx_q[wr_ptr_q]  <= s1_idx_q;
            fifo_last_q[wr_ptr_q] <= s1_last;
        end
    end

    // Occupancy is unchanged when a push and a pop coincide, even when full.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? $signed(fifo_data_q[rd_ptr_q]) : '0;
    assign out_idx_o   = out_valid_o ? fifo_idx_q[rd_ptr_q] : '0;
    assign out_last_o  = out_valid_o && fifo_last_q[rd_ptr_q];

    assign busy_o = (state_q == ISSUE) || (state_q == FLUSH);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_output_drain.sv
// Directed bench for output_drain with a queue scoreboard: expected outputs
// are pushed when a pass is started and popped as the DUT hands them over.
module tb_output_drain;

    localparam int NF = 30;

    logic              clk = 1'b0;
    logic              general_rst_ni;
    logic              start_i;
    logic [5:0]        num_filters_i;
    logic [3:0]        shift_i;
    logic              relu_en_i;
    logic [4:0]        sel_mux_final_o;
    logic signed [15:0] final_output_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic signed [7:0] out_data_o;
    logic [4:0]        out_idx_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;

    logic signed [15:0] res [32];

    typedef struct {
        int d;
        int i;
        int l;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int n_done = 0;
    int n_vcyc = 0;
    bit rand_ready = 0;
    bit stall_prev = 0;
    logic signed [7:0] hold_d;
    logic [4:0]        hold_i;
    logic              hold_l;

    output_drain dut (
        .clk_i           (clk),
        .general_rst_ni  (general_rst_ni),
        .start_i         (start_i),
        .num_filters_i   (num_filters_i),
        .shift_i         (shift_i),
        .relu_en_i       (relu_en_i),
        .sel_mux_final_o (sel_mux_final_o),
        .final_output_i  (final_output_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_idx_o       (out_idx_o),
        .out_last_o      (out_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    // Combinational upstream result selector.
    assign final_output_i = res[sel_mux_final_o];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int quant(input int v, input int sh, input bit relu);
        int r;
        r = v;
        if (sh > 0) r = r + (1 << (sh - 1));
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // One clock: check the transfer about to happen, check hold stability, advance.
    task automatic cyc();
        exp_t e;
        if (general_rst_ni) begin
            if (stall_prev) begin
                chk("hold_valid", out_valid_o, 1);
                chk("hold_data", out_data_o, hold_d);
                chk("hold_idx", out_idx_o, hold_i);
                chk("hold_last", out_last_o, hold_l);
            end
            if (out_valid_o) n_vcyc++;
            if (out_valid_o && out_ready_i) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out_idx", out_idx_o, -1);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data_o, e.d);
                    chk("out_idx", out_idx_o, e.i);
                    chk("out_last", out_last_o, e.l);
                    $display("pop idx=%0d data=%0d last=%0d", out_idx_o, out_data_o, out_last_o);
                end
            end
            stall_prev = out_valid_o && !out_ready_i;
            hold_d = out_data_o;
            hold_i = out_idx_o;
            hold_l = out_last_o;
            if (done_o) n_done++;
        end else begin
            stall_prev = 0;
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic start_pass(input int num, input int sh, input bit relu);
        int n;
        n = (num > NF) ? NF : num;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{quant(int'(res[i]), sh, relu), i, int'(i == n - 1)});
        end
        $display("start num=%0d shift=%0d relu=%0d expect=%0d", num, sh, relu, n);
        start_i       = 1'b1;
        num_filters_i = 6'(num);
        shift_i       = 4'(sh);
        relu_en_i     = relu;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        int d0;
        k  = 0;
        d0 = n_done;
        while (n_done == d0 && k < budget) begin
            cyc();
            k++;
        end
        chk("done_seen", n_done - d0, 1);
        chk("sb_empty_at_done", sb.size(), 0);
        cyc();
        cyc();
        chk("done_single_pulse", n_done - d0, 1);
        chk("busy_after_done", busy_o, 0);
    endtask

    initial begin
        int o0;
        int v0;
        int d0;
        int k;

        general_rst_ni = 1'b0;
        start_i        = 1'b0;
        num_filters_i  = '0;
        shift_i        = '0;
        relu_en_i      = 1'b0;
        out_ready_i    = 1'b1;
        for (int i = 0; i < 32; i++) res[i] = '0;

        // Reset state.
        repeat (3) cyc();
        chk("rst_sel", sel_mux_final_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_idx", out_idx_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        general_rst_ni = 1'b1;
        cyc();

        // Basic pass with saturation and 3-cycle first-output latency.
        res[0] = 16'sd100; res[1] = -16'sd5; res[2] = 16'sd300;
        start_pass(3, 0, 0);
        chk("lat_busy_c1", busy_o, 1);
        chk("lat_valid_c1", out_valid_o, 0);
        cyc();
        chk("lat_valid_c2", out_valid_o, 0);
        cyc();
        chk("lat_valid_c3", out_valid_o, 1);
        wait_done(100);

        // Rounding shift with ReLU.
        res[0] = -16'sd40; res[1] = 16'sd24;
        start_pass(2, 4, 1);
        wait_done(100);

        // Full pass under 20 cycles of backpressure.
        for (int i = 0; i < 32; i++) res[i] = 16'((i * 1237) % 4000 - 2000);
        out_ready_i = 1'b0;
        start_pass(30, 2, 0);
        repeat (19) cyc();
        chk("stall_sel", sel_mux_final_o, 4);
        chk("stall_valid", out_valid_o, 1);
        chk("stall_busy", busy_o, 1);
        chk("stall_head_idx", out_idx_o, 0);
        out_ready_i = 1'b1;
        wait_done(300);

        // Zero filters: immediate done, no stream.
        d0 = n_done;
        v0 = n_vcyc;
        start_pass(0, 0, 0);
        chk("zero_done_c1", done_o, 1);
        chk("zero_busy_c1", busy_o, 0);
        cyc();
        chk("zero_done_c2", done_o, 0);
        repeat (3) cyc();
        chk("zero_no_valid", n_vcyc - v0, 0);
        chk("zero_one_done", n_done - d0, 1);

        // Over-range count clamps to 30, with random backpressure.
        o0 = n_out;
        rand_ready = 1;
        start_pass(31, 1, 1);
        wait_done(500);
        rand_ready = 0;
        out_ready_i = 1'b1;
        cyc();
        chk("clamp_count", n_out - o0, 30);

        // start_i while busy is ignored.
        for (int i = 0; i < 32; i++) res[i] = 16'(i * 7 + 3);
        o0 = n_out;
        start_pass(5, 0, 0);
        cyc();
        start_i = 1'b1; num_filters_i = 6'd2; shift_i = 4'd3; relu_en_i = 1'b1;
        cyc();
        start_i = 1'b0;
        wait_done(100);
        chk("busy_start_count", n_out - o0, 5);

        // Reset in the middle of a pass with the FIFO full.
        start_pass(30, 0, 0);
        k = 0;
        while (sel_mux_final_o != 5'd10 && k < 100) begin
            cyc();
            k++;
        end
        chk("mid_sel_reached", sel_mux_final_o, 10);
        out_ready_i = 1'b0;
        repeat (6) cyc();
        chk("mid_valid_before_rst", out_valid_o, 1);
        general_rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_sel", sel_mux_final_o, 0);
        sb.delete();
        cyc();
        cyc();
        general_rst_ni = 1'b1;
        out_ready_i = 1'b1;
        v0 = n_vcyc;
        repeat (4) cyc();
        chk("post_rst_no_valid", n_vcyc - v0, 0);
        o0 = n_out;
        res[0] = -16'sd77;
        start_pass(1, 0, 0);
        wait_done(100);
        chk("restart_count", n_out - o0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
